// File: rtl/uart_phy_cfg.sv
// Runtime-configurable UART PHY: shared 16x baud tick, majority-vote RX with
// parity/framing/break detection, and a valid/ready TX for 5-8 data bits.
module uart_phy_cfg #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int DIV_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic [1:0]       cfg_data_bits_i,
    input  logic [1:0]       cfg_parity_i,
    input  logic             cfg_stop2_i,
    input  logic             rx_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    output logic             rx_parity_err_o,
    output logic             rx_frame_err_o,
    output logic             rx_break_o,
    input  logic [7:0]       tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic             tx_o,
    output logic             tx_done_o
);

    if (CLK_FREQ < 1) begin : g_bad_clk_freq
        $error("uart_phy_cfg: CLK_FREQ must be positive");
    end

    // ---------------- baud generator ----------------
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] baud_cnt;
    logic             div_chg;
    logic             tick;

    assign div_chg = (cfg_div_i != div_q);
    assign tick    = !div_chg && (baud_cnt == div_q);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q    <= '0;
            baud_cnt <= '0;
        end else if (div_chg) begin
            div_q    <= cfg_div_i;
            baud_cnt <= '0;
        end else if (tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_e;

    rx_state_e  rx_state_q, rx_state_d;
    logic       rx_meta, rx_s, rx_prev;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bit;
    logic [1:0] rx_smp;
    logic [7:0] rx_shift;
    logic       rx_par_bit;
    logic [1:0] rx_nbits_q;
    logic [1:0] rx_par_q;
    logic       rx_fall, rx_mid, rx_end, rx_last, rx_par_en, rx_bit_val;

    assign rx_fall    = rx_prev && !rx_s;
    assign rx_mid     = tick && (rx_tcnt == 4'd9);
    assign rx_end     = tick && (rx_tcnt == 4'd15);
    assign rx_last    = (rx_bit == ({1'b0, rx_nbits_q} + 3'd4));
    assign rx_par_en  = ^rx_par_q;
    assign rx_bit_val = (rx_smp[0] & rx_smp[1]) | (rx_smp[0] & rx_s) | (rx_smp[1] & rx_s);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rx_state_q <= RX_IDLE;
        else         rx_state_q <= rx_state_d;
    end

    // NOTE: next-state defaults to the current state first, so no latch is inferred.
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:      if (rx_fall) rx_state_d = RX_START;
            RX_START:     if (rx_mid && rx_bit_val) rx_state_d = RX_IDLE;
                          else if (rx_end)          rx_state_d = RX_DATA;
            RX_DATA:      if (rx_end && rx_last) rx_state_d = rx_par_en ? RX_PARITY : RX_STOP;
            RX_PARITY:    if (rx_end) rx_state_d = RX_STOP;
            RX_STOP:      if (rx_mid) rx_state_d = rx_bit_val ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_s) rx_state_d = RX_IDLE;
            default:      rx_state_d = RX_IDLE;
        endcase
    end

    // NOTE: every datapath flop is reset, including rx_data_o, so outputs are defined from reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            {rx_meta, rx_s, rx_prev} <= 3'b111;
            rx_tcnt         <= '0;
            rx_bit          <= '0;
            rx_smp          <= '0;
            rx_shift        <= '0;
            rx_par_bit      <= 1'b0;
            rx_nbits_q      <= '0;
            rx_par_q        <= '0;
            rx_data_o       <= '0;
            rx_valid_o      <= 1'b0;
            rx_parity_err_o <= 1'b0;
            rx_frame_err_o  <= 1'b0;
            rx_break_o      <= 1'b0;
        end else begin
            {rx_meta, rx_s, rx_prev} <= {rx_i, rx_meta, rx_s};
            rx_valid_o      <= 1'b0;
            rx_parity_err_o <= 1'b0;
            rx_frame_err_o  <= 1'b0;
            rx_break_o      <= 1'b0;
            rx_tcnt <= (rx_state_q == RX_IDLE) ? 4'd0 : rx_tcnt + {3'd0, tick};
            if (tick && rx_tcnt == 4'd7) rx_smp[0] <= rx_s;
            if (tick && rx_tcnt == 4'd8) rx_smp[1] <= rx_s;
            case (rx_state_q)
                RX_IDLE: if (rx_fall) begin
                    rx_bit     <= '0;
                    rx_shift   <= '0;
                    rx_par_bit <= 1'b0;
                    rx_nbits_q <= cfg_data_bits_i;
                    rx_par_q   <= cfg_parity_i;
                end
                RX_DATA: begin
                    if (rx_mid) rx_shift[rx_bit] <= rx_bit_val;
                    if (rx_end) rx_bit <= rx_bit + 3'd1;
                end
                RX_PARITY: if (rx_mid) rx_par_bit <= rx_bit_val;
                RX_STOP: if (rx_mid) begin
                    rx_valid_o      <= 1'b1;
                    rx_data_o       <= rx_shift;
                    rx_parity_err_o <= rx_par_en && (^rx_shift ^ rx_par_bit ^ rx_par_q[1]);
                    rx_frame_err_o  <= !rx_bit_val;
                    rx_break_o      <= !rx_bit_val && (rx_shift == 8'h00) && !rx_par_bit;
                end
                default: ;
            endcase
        end
    end

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    tx_state_e  tx_state_q, tx_state_d;
    logic [3:0] tx_tcnt;
    logic [2:0] tx_bit;
    logic [7:0] tx_shift;
    logic [7:0] tx_masked;
    logic [1:0] tx_nbits_q;
    logic       tx_par_en_q, tx_par_bit_q, tx_stop2_q, tx_stop_idx;
    logic       tx_end, tx_last;

    assign tx_ready_o = (tx_state_q == TX_IDLE);
    assign tx_end     = tick && (tx_tcnt == 4'd15);
    assign tx_last    = (tx_bit == ({1'b0, tx_nbits_q} + 3'd4));
    assign tx_masked  = tx_data_i & (8'hFF >> (2'd3 - cfg_data_bits_i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tx_state_q <= TX_IDLE;
        else         tx_state_q <= tx_state_d;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_done_o  = 1'b0;
        case (tx_state_q)
            TX_IDLE:   if (tx_valid_i) tx_state_d = TX_START;
            TX_START:  if (tx_end) tx_state_d = TX_DATA;
            TX_DATA:   if (tx_end && tx_last) tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_end) tx_state_d = TX_STOP;
            TX_STOP: if (tx_end && (tx_stop_idx || !tx_stop2_q)) begin
                tx_state_d = TX_IDLE;
                tx_done_o  = 1'b1;
            end
            default:   tx_state_d = TX_IDLE;
        endcase
    end

    // The line level for the next bit is registered on the tick that ends the current one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_o         <= 1'b1;
            tx_tcnt      <= '0;
            tx_bit       <= '0;
            tx_shift     <= '0;
            tx_nbits_q   <= '0;
            tx_par_en_q  <= 1'b0;
            tx_par_bit_q <= 1'b0;
            tx_stop2_q   <= 1'b0;
            tx_stop_idx  <= 1'b0;
        end else begin
            tx_tcnt <= (tx_state_q == TX_IDLE) ? 4'd0 : tx_tcnt + {3'd0, tick};
            case (tx_state_q)
                TX_IDLE: if (tx_valid_i) begin
                    tx_o         <= 1'b0;
                    tx_bit       <= '0;
                    tx_shift     <= tx_masked;
                    tx_nbits_q   <= cfg_data_bits_i;
                    tx_par_en_q  <= ^cfg_parity_i;
                    tx_par_bit_q <= ^tx_masked ^ cfg_parity_i[1];
                    tx_stop2_q   <= cfg_stop2_i;
                    tx_stop_idx  <= 1'b0;
                end
                TX_START: if (tx_end) tx_o <= tx_shift[0];
                TX_DATA: if (tx_end) begin
                    if (!tx_last) begin
                        tx_bit   <= tx_bit + 3'd1;
                        tx_shift <= tx_shift >> 1;
                        tx_o     <= tx_shift[1];
                    end else begin
                        tx_o <= tx_par_en_q ? tx_par_bit_q : 1'b1;
                    end
                end
                TX_PARITY: if (tx_end) tx_o <= 1'b1;
                TX_STOP:   if (tx_end) tx_stop_idx <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_phy_cfg.sv
// Directed bench for uart_phy_cfg: TX framing, loopback, RX error cases,
// false start, async reset mid-frame and baud divisor change.
module tb_uart_phy_cfg;
    localparam int CLK_FREQ = 100_000_000;
    localparam int DIV_W    = 16;
    localparam int BIT_CLK  = 64;   // cfg_div_i = 3 -> 4 clk/tick * 16

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [DIV_W-1:0] cfg_div_i;
    logic [1:0]       cfg_data_bits_i;
    logic [1:0]       cfg_parity_i;
    logic             cfg_stop2_i;
    logic             rx_i;
    logic [7:0]       rx_data_o;
    logic             rx_valid_o, rx_parity_err_o, rx_frame_err_o, rx_break_o;
    logic [7:0]       tx_data_i;
    logic             tx_valid_i, tx_ready_o, tx_o, tx_done_o;

    logic rx_drv;
    logic loop_en;
    int   n_cmp = 0;
    int   n_mis = 0;

    int         rx_seen = 0;
    logic [7:0] rx_cap_data;
    logic       rx_cap_pe, rx_cap_fe, rx_cap_brk;

    always #5 clk_i = ~clk_i;

    assign rx_i = loop_en ? tx_o : rx_drv;

    uart_phy_cfg #(.CLK_FREQ(CLK_FREQ), .DIV_W(DIV_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cfg_div_i(cfg_div_i),
        .cfg_data_bits_i(cfg_data_bits_i), .cfg_parity_i(cfg_parity_i),
        .cfg_stop2_i(cfg_stop2_i), .rx_i(rx_i), .rx_data_o(rx_data_o),
        .rx_valid_o(rx_valid_o), .rx_parity_err_o(rx_parity_err_o),
        .rx_frame_err_o(rx_frame_err_o), .rx_break_o(rx_break_o),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .tx_o(tx_o), .tx_done_o(tx_done_o)
    );

    always @(negedge clk_i) begin
        if (rx_valid_o === 1'b1) begin
            rx_seen++;
            rx_cap_data = rx_data_o;
            rx_cap_pe   = rx_parity_err_o;
            rx_cap_fe   = rx_frame_err_o;
            rx_cap_brk  = rx_break_o;
        end
    end

    // Send one byte aligned so a tick falls in the handshake cycle, then compare
    // every line cycle against the hand-computed slot pattern (slot i = pat[i]).
    task automatic tx_frame(input string name, input logic [7:0] data,
                            input logic [15:0] pat, input int nslots);
        int bad [16];
        int rdy_bad, done_cnt, done_at, waited, total;
        total = nslots * BIT_CLK;
        foreach (bad[i]) bad[i] = 0;
        rdy_bad = 0; done_cnt = 0; done_at = 0; waited = 0;
        while (dut.tick !== 1'b1 && waited < 100) begin
            @(negedge clk_i);
            waited++;
        end
        n_cmp++;
        if (dut.tick !== 1'b1) begin
            n_mis++;
            $display("FAIL %s_align: no baud tick within %0d cycles", name, waited);
        end
        n_cmp++;
        if (tx_ready_o !== 1'b1) begin
            n_mis++;
            $display("FAIL %s_ready_idle: got %b want 1", name, tx_ready_o);
        end
        tx_data_i  = data;
        tx_valid_i = 1'b1;
        @(negedge clk_i);
        tx_valid_i = 1'b0;
        for (int k = 1; k <= total + 1; k++) begin
            if (k <= total) begin
                if (tx_o !== pat[(k-1)/BIT_CLK]) bad[(k-1)/BIT_CLK]++;
                if (tx_ready_o !== 1'b0) rdy_bad++;
            end
            if (tx_done_o === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (k <= total) @(negedge clk_i);
        end
        for (int s = 0; s < nslots; s++) begin
            n_cmp++;
            if (bad[s] != 0) begin
                n_mis++;
                $display("FAIL %s_slot%0d: %0d of %0d cycles wrong, want level %b", name, s, bad[s], BIT_CLK, pat[s]);
            end
        end
        n_cmp++;
        if (rdy_bad != 0) begin
            n_mis++;
            $display("FAIL %s_ready_busy: high in %0d frame cycles, want 0", name, rdy_bad);
        end
        n_cmp++;
        if (done_cnt != 1 || done_at != total) begin
            n_mis++;
            $display("FAIL %s_done: %0d pulses, last at cycle %0d, want 1 at %0d", name, done_cnt, done_at, total);
        end
        n_cmp++;
        if (tx_ready_o !== 1'b1 || tx_o !== 1'b1) begin
            n_mis++;
            $display("FAIL %s_after: ready=%b tx=%b want 1/1", name, tx_ready_o, tx_o);
        end
    endtask

    task automatic rx_frame(input logic [15:0] pat, input int nslots);
        for (int s = 0; s < nslots; s++) begin
            rx_drv = pat[s];
            repeat (BIT_CLK) @(negedge clk_i);
        end
        rx_drv = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #23;
        n_cmp++;
        if (tx_o !== 1'b1 || tx_ready_o !== 1'b1) begin
            n_mis++;
            $display("FAIL reset_tx: tx=%b ready=%b want 1/1", tx_o, tx_ready_o);
        end
        n_cmp++;
        if (tx_done_o !== 1'b0 || rx_valid_o !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_pulses: done=%b rx_valid=%b want 0/0", tx_done_o, rx_valid_o);
        end
        n_cmp++;
        if (rx_data_o !== 8'h00) begin
            n_mis++;
            $display("FAIL reset_rx_data: got %h want 00", rx_data_o);
        end
        n_cmp++;
        if ({rx_parity_err_o, rx_frame_err_o, rx_break_o} !== 3'b000) begin
            n_mis++;
            $display("FAIL reset_flags: got %b want 000", {rx_parity_err_o, rx_frame_err_o, rx_break_o});
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (8) @(negedge clk_i);
    endtask

    task automatic test_tx_8n1();
        // 0x55 8N1: start 0, 1,0,1,0,1,0,1,0, stop 1
        tx_frame("tx_8n1_55", 8'h55, 16'h02AA, 10);
    endtask

    task automatic test_loopback_7e2();
        int base;
        cfg_data_bits_i = 2'b10;
        cfg_parity_i    = 2'b01;
        cfg_stop2_i     = 1'b1;
        loop_en         = 1'b1;
        base            = rx_seen;
        // 0xC5 -> 7 bits 0x45 (three ones): start 0, 1,0,1,0,0,0,1, parity 1, stop 1,1
        tx_frame("loop_7e2_c5", 8'hC5, 16'h078A, 11);
        repeat (BIT_CLK) @(negedge clk_i);
        loop_en = 1'b0;
        n_cmp++;
        if (rx_seen - base != 1) begin
            n_mis++;
            $display("FAIL loop_rx_count: got %0d want 1", rx_seen - base);
        end
        n_cmp++;
        if (rx_cap_data !== 8'h45) begin
            n_mis++;
            $display("FAIL loop_rx_data: got %h want 45", rx_cap_data);
        end
        n_cmp++;
        if ({rx_cap_pe, rx_cap_fe, rx_cap_brk} !== 3'b000) begin
            n_mis++;
            $display("FAIL loop_rx_flags: got %b want 000", {rx_cap_pe, rx_cap_fe, rx_cap_brk});
        end
    endtask

    task automatic test_parity_err();
        int base;
        cfg_data_bits_i = 2'b11;
        cfg_parity_i    = 2'b10;
        cfg_stop2_i     = 1'b0;
        base            = rx_seen;
        // start 0, eight 0 data bits, parity 0 (odd wants 1), stop 1
        rx_frame(16'h0400, 11);
        repeat (BIT_CLK) @(negedge clk_i);
        n_cmp++;
        if (rx_seen - base != 1) begin
            n_mis++;
            $display("FAIL par_rx_count: got %0d want 1", rx_seen - base);
        end
        n_cmp++;
        if (rx_cap_data !== 8'h00) begin
            n_mis++;
            $display("FAIL par_rx_data: got %h want 00", rx_cap_data);
        end
        n_cmp++;
        if ({rx_cap_pe, rx_cap_fe, rx_cap_brk} !== 3'b100) begin
            n_mis++;
            $display("FAIL par_rx_flags: pe/fe/brk got %b want 100", {rx_cap_pe, rx_cap_fe, rx_cap_brk});
        end
    endtask

    task automatic test_break();
        int base;
        cfg_data_bits_i = 2'b11;
        cfg_parity_i    = 2'b00;
        base            = rx_seen;
        rx_drv = 1'b0;
        repeat (20 * BIT_CLK) @(negedge clk_i);
        rx_drv = 1'b1;
        repeat (5 * BIT_CLK) @(negedge clk_i);
        n_cmp++;
        if (rx_seen - base != 1) begin
            n_mis++;
            $display("FAIL brk_rx_count: got %0d want 1", rx_seen - base);
        end
        n_cmp++;
        if (rx_cap_data !== 8'h00) begin
            n_mis++;
            $display("FAIL brk_rx_data: got %h want 00", rx_cap_data);
        end
        n_cmp++;
        if ({rx_cap_pe, rx_cap_fe, rx_cap_brk} !== 3'b011) begin
            n_mis++;
            $display("FAIL brk_rx_flags: pe/fe/brk got %b want 011", {rx_cap_pe, rx_cap_fe, rx_cap_brk});
        end
    endtask

    task automatic test_false_start();
        int base;
        base   = rx_seen;
        rx_drv = 1'b0;
        repeat (16) @(negedge clk_i);
        rx_drv = 1'b1;
        repeat (3 * BIT_CLK) @(negedge clk_i);
        n_cmp++;
        if (rx_seen - base != 0) begin
            n_mis++;
            $display("FAIL false_start_count: got %0d want 0", rx_seen - base);
        end
        // 0xA3 8N1: start 0, 1,1,0,0,0,1,0,1, stop 1
        rx_frame(16'h0346, 10);
        repeat (BIT_CLK) @(negedge clk_i);
        n_cmp++;
        if (rx_seen - base != 1 || rx_cap_data !== 8'hA3) begin
            n_mis++;
            $display("FAIL after_false_start: count %0d data %h want 1 / a3", rx_seen - base, rx_cap_data);
        end
        n_cmp++;
        if ({rx_cap_pe, rx_cap_fe, rx_cap_brk} !== 3'b000) begin
            n_mis++;
            $display("FAIL after_false_start_flags: got %b want 000", {rx_cap_pe, rx_cap_fe, rx_cap_brk});
        end
    endtask

    task automatic test_reset_mid_tx();
        int done_cnt, rdy_low;
        done_cnt = 0; rdy_low = 0;
        tx_data_i  = 8'h55;
        tx_valid_i = 1'b1;
        @(negedge clk_i);
        tx_valid_i = 1'b0;
        repeat (150) @(negedge clk_i);   // inside data bit 1 (line low)
        n_cmp++;
        if (tx_o !== 1'b0) begin
            n_mis++;
            $display("FAIL rst_pre_low: tx got %b want 0", tx_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (tx_o !== 1'b1 || tx_ready_o !== 1'b1) begin
            n_mis++;
            $display("FAIL rst_async: tx=%b ready=%b want 1/1", tx_o, tx_ready_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 12 * BIT_CLK; k++) begin
            @(negedge clk_i);
            if (tx_done_o === 1'b1) done_cnt++;
            if (tx_ready_o !== 1'b1) rdy_low++;
        end
        n_cmp++;
        if (done_cnt != 0 || rdy_low != 0) begin
            n_mis++;
            $display("FAIL rst_after: done pulses %0d, ready-low cycles %0d, want 0/0", done_cnt, rdy_low);
        end
    endtask

    task automatic test_div_change();
        logic [11:0] tick_pat;
        int waited;
        tick_pat  = '0;
        cfg_div_i = 16'd1;
        repeat (10) @(negedge clk_i);
        tx_data_i  = 8'h55;
        tx_valid_i = 1'b1;
        @(negedge clk_i);
        tx_valid_i = 1'b0;
        repeat (40) @(negedge clk_i);
        cfg_div_i = 16'd3;
        #1;
        n_cmp++;
        if (dut.tick !== 1'b0) begin
            n_mis++;
            $display("FAIL div_change_cycle_tick: got %b want 0", dut.tick);
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_i);
            if (dut.tick === 1'b1) tick_pat[k-1] = 1'b1;
        end
        n_cmp++;
        if (tick_pat !== 12'h888) begin
            n_mis++;
            $display("FAIL div_change_spacing: tick pattern %b want 100010001000", tick_pat);
        end
        waited = 0;
        while (tx_done_o !== 1'b1 && waited < 2000) begin
            @(negedge clk_i);
            waited++;
        end
        n_cmp++;
        if (tx_done_o !== 1'b1) begin
            n_mis++;
            $display("FAIL div_change_done: no tx_done_o within %0d cycles", waited);
        end
        repeat (4) @(negedge clk_i);
    endtask

    initial begin
        rst_ni          = 1'b0;
        cfg_div_i       = 16'd3;
        cfg_data_bits_i = 2'b11;
        cfg_parity_i    = 2'b00;
        cfg_stop2_i     = 1'b0;
        tx_data_i       = 8'h00;
        tx_valid_i      = 1'b0;
        rx_drv          = 1'b1;
        loop_en         = 1'b0;

        test_reset();
        test_tx_8n1();
        test_loopback_7e2();
        test_parity_err();
        test_break();
        test_false_start();
        test_reset_mid_tx();
        test_div_change();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
